// File: rtl/mem_debug_dumper.sv
// Walks every word of the data memory through its debug read port and streams
// each word out as NB_DATA/NB_BYTE bytes, LSB first, on a valid/ready byte link.
module mem_debug_dumper #(
    parameter int NB_DEPTH = 8,
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_DATA-1:0]    i_data_debug,
    input  logic                  i_tx_ready,
    output logic [NB_DEPTH-3:0]   o_addr_debug,
    output logic                  o_debug_enb,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NB_ADDR  = NB_DEPTH - 2;
    localparam int N_BYTES  = NB_DATA / NB_BYTE;
    localparam int NB_CNT   = $clog2(N_BYTES);

    generate
        if (NB_DATA != 4 * NB_BYTE) begin : g_bad_width
            $error("NB_DATA must equal 4*NB_BYTE");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t              state, state_next;
    logic [NB_ADDR-1:0]  addr, addr_next;
    logic [NB_DATA-1:0]  shreg, shreg_next;
    logic [NB_CNT-1:0]   cnt, cnt_next;
    logic                xfer;
    logic                last_byte;

    // Handshake only looks at registered state, so valid never follows ready.
    assign xfer      = (state == ST_SEND) && i_tx_ready;
    assign last_byte = (cnt == NB_CNT'(N_BYTES - 1));

    always_comb begin
        state_next = state;
        addr_next  = addr;
        shreg_next = shreg;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    addr_next  = '0;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: state_next = ST_WAIT;
            ST_WAIT: begin
                shreg_next = i_data_debug;
                cnt_next   = '0;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    shreg_next = shreg >> NB_BYTE;
                    cnt_next   = cnt + NB_CNT'(1);
                    if (last_byte) begin
                        if (&addr) begin
                            state_next = ST_DONE;
                        end else begin
                            addr_next  = addr + NB_ADDR'(1);
                            state_next = ST_ADDR;
                        end
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            addr  <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

    assign o_addr_debug = addr;
    assign o_debug_enb  = (state == ST_IDLE) || (state == ST_DONE);
    assign o_tx_valid   = (state == ST_SEND);
    assign o_tx_data    = shreg[NB_BYTE-1:0];
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Directed bench for mem_debug_dumper: registered debug-read memory model,
// byte collector and hand-computed expectations for each scenario.
module tb_mem_debug_dumper;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [31:0] i_data_debug;
    logic        i_tx_ready;
    logic [5:0]  o_addr_debug;
    logic        o_debug_enb;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_done;

    mem_debug_dumper dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_data_debug (i_data_debug),
        .i_tx_ready   (i_tx_ready),
        .o_addr_debug (o_addr_debug),
        .o_debug_enb  (o_debug_enb),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory debug port: registered read, only while in debug mode.
    logic [31:0] mem [64];
    logic [31:0] rd_q;
    always @(posedge i_clk) if (!o_debug_enb) rd_q <= mem[o_addr_debug];
    assign i_data_debug = rd_q;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] got [$];
    int         cyc, done_cnt, done_cyc, enb_bad, stab_bad, mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = 32'hA0B0C000 + 32'(i / 4);
        return w[8*(i%4) +: 8];
    endfunction

    function automatic int seq_errs();
        int e = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== exp_byte(i)) e++;
        return e;
    endfunction

    // One clock: drive ready, observe pre-edge handshake, advance, check stall hold.
    task automatic step();
        logic       stall;
        logic [7:0] pd;
        case (mode)
            0: i_tx_ready = 1'b1;
            1: i_tx_ready = (cyc % 3 == 0);
            default: i_tx_ready = 1'b0;
        endcase
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_busy && !o_done && o_debug_enb) enb_bad++;
        if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
        stall = o_tx_valid && !i_tx_ready;
        pd    = o_tx_data;
        @(posedge i_clk);
        #1;
        cyc++;
        if (stall && (o_tx_valid !== 1'b1 || o_tx_data !== pd)) stab_bad++;
    endtask

    task automatic begin_dump();
        got.delete();
        done_cnt = 0; done_cyc = -1; enb_bad = 0; stab_bad = 0; cyc = 0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic finish_dump();
        int n = 0;
        while (done_cnt == 0 && n < 5000) begin step(); n++; end
        repeat (3) step();
    endtask

    initial begin
        int bad;
        for (int k = 0; k < 64; k++) mem[k] = 32'hA0B0C000 + 32'(k);
        i_rst = 1'b1; i_start = 1'b0; i_tx_ready = 1'b1; mode = 0; cyc = 0;
        done_cnt = 0; done_cyc = -1; enb_bad = 0; stab_bad = 0;
        repeat (3) step();

        chk("rst_busy",  o_busy, 0);
        chk("rst_valid", o_tx_valid, 0);
        chk("rst_enb",   o_debug_enb, 1);
        chk("rst_addr",  o_addr_debug, 0);
        chk("rst_data",  o_tx_data, 0);
        chk("rst_done",  o_done, 0);
        i_rst = 1'b0;

        // Idle, no start
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_debug_enb !== 1'b1 || o_busy !== 1'b0 || o_tx_valid !== 1'b0 || o_addr_debug !== 6'd0) bad++;
        end
        chk("idle_hold", bad, 0);

        // Full dump, ready always high
        mode = 0;
        begin_dump();
        finish_dump();
        chk("full_len", got.size(), 256);
        chk("full_b0", {got[3], got[2], got[1], got[0]}, 32'hA0B0C000);
        chk("full_last", {got[255], got[254], got[253], got[252]}, 32'hA0B0C03F);
        chk("full_seq", seq_errs(), 0);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_done_cyc", done_cyc, 385);
        chk("full_enb_in_dump", enb_bad, 0);
        chk("full_enb_after", o_debug_enb, 1);
        chk("full_busy_after", o_busy, 0);

        // Ready 1-of-3
        mode = 1;
        begin_dump();
        finish_dump();
        chk("slow_len", got.size(), 256);
        chk("slow_seq", seq_errs(), 0);
        chk("slow_stable", stab_bad, 0);
        chk("slow_done_cnt", done_cnt, 1);

        // Reset during word 10, byte 2
        mode = 0;
        begin_dump();
        bad = 0;
        while (got.size() < 42 && bad < 2000) begin step(); bad++; end
        chk("mid_valid", o_tx_valid, 1);
        chk("mid_byte", o_tx_data, 8'hB0);
        chk("mid_addr", o_addr_debug, 10);
        i_rst = 1'b1;
        step();
        chk("mid_rst_valid", o_tx_valid, 0);
        chk("mid_rst_enb", o_debug_enb, 1);
        chk("mid_rst_busy", o_busy, 0);
        i_rst = 1'b0;
        step();
        begin_dump();
        finish_dump();
        chk("restart_first", got.size() > 0 ? got[0] : 8'hxx, 8'h00);
        chk("restart_len", got.size(), 256);
        chk("restart_seq", seq_errs(), 0);

        // Start re-pulsed at word 5
        begin_dump();
        bad = 0;
        while (got.size() < 20 && bad < 2000) begin step(); bad++; end
        i_start = 1'b1;
        repeat (3) step();
        i_start = 1'b0;
        finish_dump();
        chk("repulse_len", got.size(), 256);
        chk("repulse_seq", seq_errs(), 0);
        chk("repulse_done_cnt", done_cnt, 1);
        chk("repulse_busy_after", o_busy, 0);

        // Ready held low 1000 cycles at word 0 byte 0
        mode = 2;
        begin_dump();
        bad = 0;
        while (o_tx_valid !== 1'b1 && bad < 20) begin step(); bad++; end
        repeat (1000) step();
        chk("stall_valid", o_tx_valid, 1);
        chk("stall_data", o_tx_data, 8'h00);
        chk("stall_addr", o_addr_debug, 0);
        chk("stall_no_bytes", got.size(), 0);
        chk("stall_stable", stab_bad, 0);
        mode = 0;
        finish_dump();
        chk("stall_len", got.size(), 256);
        chk("stall_seq", seq_errs(), 0);
        chk("stall_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
